param_fifo: RTL

PARAM_FIFO -- requirements
Module: param_fifo

---
 rtl/fifo_pkg.sv | 23 ++
 rtl/fifo_mem.sv | 33 +++
 rtl/param_fifo.sv | 110 +++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_pkg
// Description : Default FIFO sizing constants and pointer/count width helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_DEPTH = 16;

    // Address width for a storage array of the given depth (at least one bit).
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Occupancy counter must represent 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage : fifo_pkg
`default_nettype wire

// File: rtl/fifo_mem.sv
`default_nettype none
// ============================================================================
// Module      : fifo_mem
// Description : DEPTH x WIDTH storage, one synchronous write port, one
//               asynchronous read port; contents are never reset.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                        clk,
    input  logic                        i_we,
    input  logic [ptr_width(DEPTH)-1:0] i_waddr,
    input  logic [WIDTH-1:0]            i_wdata,
    input  logic [ptr_width(DEPTH)-1:0] i_raddr,
    output logic [WIDTH-1:0]            o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule : fifo_mem
`default_nettype wire

// File: rtl/param_fifo.sv
`default_nettype none
// ============================================================================
// Module      : param_fifo
// Description : Parameterised synchronous FIFO with registered output,
//               occupancy count, status flags and overflow/underflow pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module param_fifo
    import fifo_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int DEPTH    = DEFAULT_DEPTH,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        flush,
    input  logic                        wr_en,
    input  logic                        rd_en,
    input  logic [WIDTH-1:0]            in,
    output logic [WIDTH-1:0]            out,
    output logic [cnt_width(DEPTH)-1:0] count,
    output logic                        full,
    output logic                        empty,
    output logic                        almost_full,
    output logic                        almost_empty,
    output logic                        overflow,
    output logic                        underflow
);

    localparam int c_PTR_W = ptr_width(DEPTH);
    localparam int c_CNT_W = cnt_width(DEPTH);

    localparam logic [c_CNT_W-1:0] c_FULL_CNT = c_CNT_W'(DEPTH);
    localparam logic [c_CNT_W-1:0] c_AF_CNT   = c_CNT_W'(AF_LEVEL);
    localparam logic [c_CNT_W-1:0] c_AE_CNT   = c_CNT_W'(AE_LEVEL);

    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic [WIDTH-1:0]   r_out;
    logic               r_overflow;
    logic               r_underflow;

    logic               w_rd_acc;
    logic               w_wr_acc;
    logic               w_mem_we;
    logic [WIDTH-1:0]   w_rdata;

    // A read frees a slot in the same edge, so a full FIFO can still accept a write.
    assign w_rd_acc = rd_en && !empty && !flush;
    assign w_wr_acc = wr_en && (!full || w_rd_acc) && !flush;
    assign w_mem_we = w_wr_acc && !reset;

    fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_mem_we),
        .i_waddr (r_wr_ptr),
        .i_wdata (in),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_out       <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (flush) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= wr_en && !w_wr_acc;
            r_underflow <= rd_en && !w_rd_acc;
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
                r_out    <= w_rdata;
            end
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign out          = r_out;
    assign count        = r_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;
    assign full         = (r_count == c_FULL_CNT);
    assign empty        = (r_count == '0);
    assign almost_full  = (r_count >= c_AF_CNT);
    assign almost_empty = (r_count <= c_AE_CNT);

endmodule : param_fifo
`default_nettype wire
